cpu_trace_im_buffer: RTL
========================

Name: cpu_trace_im_buffer

Overview:
- On-chip instruction-trace capture buffer for the CPU debug slave.
- Stores CPU trace frames in a circular RAM and maintains the write pointer and wrap flag.
- Drives the trace status and readout inputs of the debug-slave wrapper: trc_on, trc_wrap, trc_im_addr, tracemem_on, tracemem_trcdata, tracemem_tw.
- Readout is controlled from the JTAG-to-sysclk action strobes with jdo as the data bus.

Parameters:
- ADDR_W, 7: trace RAM address width; depth = 2**ADDR_W = 128 entries.
- DATA_W, 36: trace frame width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- trace_valid  in  1  CPU presents a trace frame this cycle.
- trace_data  in  DATA_W  trace frame from the CPU.
- jdo  in  38  JTAG data-out, sysclk-synchronous.
- take_action_tracectrl  in  1  one-cycle strobe: load trace control from jdo.
- take_action_tracemem_a  in  1  one-cycle strobe: load read address from jdo[ADDR_W-1:0].
- take_no_action_tracemem_a  in  1  one-cycle strobe: advance read address.
- trc_on  out  1  capture enabled.
- trc_wrap  out  1  sticky flag: write pointer has wrapped.
- trc_im_addr  out  ADDR_W  next write address.
- tracemem_on  out  1  equals trc_on; registered copy.
- tracemem_trcdata  out  DATA_W  frame at the current read address.
- tracemem_tw  out  1  entry at the read address was written since the last clear.

Behaviour:
- Reset (async, active-high) forces all registers to zero: trc_on, tracemem_on, trc_wrap, trc_im_addr, rd_addr, tracemem_trcdata, tracemem_tw, and all 128 valid bits. RAM contents are not reset.
- Control is applied on take_action_tracectrl:
  - trc_on <= jdo[0].
  - If jdo[1]=1: trc_im_addr <= 0, trc_wrap <= 0, all valid bits <= 0.
  - tracemem_on follows trc_on one cycle later.
- Capture happens when trc_on && trace_valid && !(take_action_tracectrl && jdo[1]):
  - mem[trc_im_addr] <= trace_data; valid[trc_im_addr] <= 1; trc_im_addr <= trc_im_addr + 1, modulo 2**ADDR_W.
  - When trc_im_addr == 2**ADDR_W-1 and a capture occurs: trc_im_addr wraps to 0 and trc_wrap <= 1. trc_wrap is sticky until a clear or reset.
  - Back-to-back capture every cycle is supported; there is no stall or backpressure, and old entries are overwritten after a wrap.
- Simultaneous clear and capture: the clear wins; the frame is dropped; addr = 0 and valid = 0 afterwards.
- Simultaneous tracectrl with trc_on 1->0 and trace_valid: that frame is still captured, because trc_on is sampled before the update. A 0->1 change takes effect the next cycle.
- Read pointer rd_addr:
  - take_action_tracemem_a: rd_addr <= jdo[ADDR_W-1:0].
  - take_no_action_tracemem_a: rd_addr <= rd_addr + 1 (wraps).
  - If both strobes are asserted, load wins.
- Read data:
  - tracemem_trcdata and tracemem_tw are registered from mem[rd_addr] and valid[rd_addr].
  - The result is visible 2 cycles after the strobe: 1 cycle pointer update, 1 cycle RAM read.
  - The RAM is simple dual-port: one write port and one synchronous read port.
- Read/write same address in the same cycle: the read returns old data (read-during-write = old) and the old valid bit. The new value appears on the next read.
- Reset mid-capture: the pointer and flags clear immediately; a partially observed frame is discarded.

Test Plan:
- Reset -> all outputs 0. Then tracectrl with jdo = 38'h1 -> trc_on = 1 next cycle, tracemem_on = 1 one cycle later.
- trc_on = 1, 5 consecutive trace_valid frames 36'hA00000000..36'hA00000004 -> trc_im_addr = 5, trc_wrap = 0. Then load rd_addr = 2 and wait 2 cycles -> tracemem_trcdata = 36'hA00000002, tracemem_tw = 1. Read rd_addr = 7 -> tracemem_tw = 0.
- 130 captures from addr 0 -> trc_im_addr = 2 and trc_wrap = 1 (set on the 128th capture). Reading addr 0 -> frame #128 (zero-based index).
- Clear (jdo = 38'h3) coincident with trace_valid -> trc_im_addr = 0, trc_wrap = 0, the frame is not stored, and every tw reads 0.
- Load rd_addr = 127, then take_no_action_tracemem_a -> rd_addr = 0. Load and advance in the same cycle -> the load value is used.
- Reset asserted asynchronously mid-burst with trc_im_addr = 40 -> outputs 0 without a clock edge. Captures resume at addr 0 only after a new tracectrl with jdo[0] = 1.

Source files
------------

// File: rtl/cpu_trace_im_buffer.sv
// ---------------------------------------------------------------------------
// cpu_trace_im_buffer
//
// On-chip instruction-trace capture buffer for the CPU debug slave. CPU trace
// frames are written into a circular RAM at the write pointer. A sticky flag
// records that the pointer has wrapped. A JTAG-driven read pointer selects
// one entry. That entry and its "written since last clear" bit are presented
// registered to the debug-slave wrapper.
//
// Ports:
//   clk                       in   system clock, rising edge
//   reset                     in   asynchronous, active-high reset
//   trace_valid               in   CPU presents a trace frame this cycle
//   trace_data                in   trace frame (DATA_W bits)
//   jdo                       in   JTAG data-out bus (38 bits, sysclk domain)
//   take_action_tracectrl     in   strobe: jdo[0] = capture on, jdo[1] = clear
//   take_action_tracemem_a    in   strobe: load read address from jdo
//   take_no_action_tracemem_a in   strobe: advance read address
//   trc_on                    out  capture enabled
//   trc_wrap                  out  sticky: write pointer has wrapped
//   trc_im_addr               out  next write address
//   tracemem_on               out  trc_on delayed by one cycle
//   tracemem_trcdata          out  frame at the read address (registered)
//   tracemem_tw               out  read entry written since last clear
// ---------------------------------------------------------------------------
module cpu_trace_im_buffer #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 36
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trace_valid,
    input  logic [DATA_W-1:0] trace_data,
    input  logic [37:0]       jdo,
    input  logic              take_action_tracectrl,
    input  logic              take_action_tracemem_a,
    input  logic              take_no_action_tracemem_a,
    output logic              trc_on,
    output logic              trc_wrap,
    output logic [ADDR_W-1:0] trc_im_addr,
    output logic              tracemem_on,
    output logic [DATA_W-1:0] tracemem_trcdata,
    output logic              tracemem_tw
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic              r_trcOn;
    logic              r_tracememOn;
    logic              r_trcWrap;
    logic [ADDR_W-1:0] r_imAddr;
    logic [ADDR_W-1:0] r_rdAddr;
    logic [DATA_W-1:0] r_trcData;
    logic              r_tw;

    logic              w_clear;
    logic              w_capture;
    logic              w_unusedJdo;

    // A clear takes priority over a capture in the same cycle, so the frame
    // is dropped. Capture uses the pre-update trc_on, which means a frame
    // arriving together with a switch-off is still stored.
    assign w_clear     = take_action_tracectrl & jdo[1];
    assign w_capture   = r_trcOn & trace_valid & ~w_clear;
    assign w_unusedJdo = ^jdo[37:ADDR_W];

    // Trace RAM write port. The contents are deliberately left unreset so
    // the array can map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_mem[r_imAddr] <= trace_data;
        end
    end

    // Control, write pointer, wrap flag and per-entry written bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_trcOn      <= 1'b0;
            r_tracememOn <= 1'b0;
            r_trcWrap    <= 1'b0;
            r_imAddr     <= '0;
            r_valid      <= '0;
        end else begin
            r_tracememOn <= r_trcOn;
            if (take_action_tracectrl) begin
                r_trcOn <= jdo[0];
            end
            if (w_clear) begin
                r_imAddr  <= '0;
                r_trcWrap <= 1'b0;
                r_valid   <= '0;
            end else if (w_capture) begin
                r_valid[r_imAddr] <= 1'b1;
                r_imAddr          <= r_imAddr + ADDR_ONE;
                if (r_imAddr == ADDR_MAX) begin
                    r_trcWrap <= 1'b1;
                end
            end
        end
    end

    // Read pointer plus the synchronous read port. The read samples the RAM
    // and written bits before this cycle's write lands, giving old data on a
    // same-address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdAddr  <= '0;
            r_trcData <= '0;
            r_tw      <= 1'b0;
        end else begin
            if (take_action_tracemem_a) begin
                r_rdAddr <= jdo[ADDR_W-1:0];
            end else if (take_no_action_tracemem_a) begin
                r_rdAddr <= r_rdAddr + ADDR_ONE;
            end
            r_trcData <= r_mem[r_rdAddr];
            r_tw      <= r_valid[r_rdAddr];
        end
    end

    assign trc_on           = r_trcOn;
    assign trc_wrap         = r_trcWrap;
    assign trc_im_addr      = r_imAddr;
    assign tracemem_on      = r_tracememOn;
    assign tracemem_trcdata = r_trcData;
    assign tracemem_tw      = r_tw;

endmodule
